// File: rtl/countdown_timer_core.sv
// rtl/countdown_timer_core.sv - hh:mm:ss countdown timer with prescaler, run control and timed buzzer
module countdown_timer_core #(
   parameter int unsigned CLK_DIV      = 50_000_000,
   parameter int unsigned HOUR_W       = 4,
   parameter int unsigned BUZZ_SECONDS = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              load,
   input  logic              start,
   input  logic              pause,
   input  logic [HOUR_W-1:0] load_hours,
   input  logic [5:0]        load_minutes,
   input  logic [5:0]        load_seconds,
   output logic [HOUR_W-1:0] cur_hours,
   output logic [5:0]        cur_minutes,
   output logic [5:0]        cur_seconds,
   output logic              running,
   output logic              expired,
   output logic              buzzer
);

   localparam int unsigned PW = $clog2(CLK_DIV);
   localparam int unsigned BW = (BUZZ_SECONDS > 1) ? $clog2(BUZZ_SECONDS) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BUZZ_LAST = BW'(BUZZ_SECONDS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_PAUSED,
      S_ALARM
   } state_t;

   state_t            state_q, state_d;
   logic [HOUR_W-1:0] hours_q, hours_d;
   logic [5:0]        minutes_q, minutes_d;
   logic [5:0]        seconds_q, seconds_d;
   logic [PW-1:0]     presc_q, presc_d;
   logic [BW-1:0]     buzz_cnt_q, buzz_cnt_d;
   logic              running_q, running_d;
   logic              expired_q, expired_d;
   logic              buzzer_q, buzzer_d;

   logic              tick;
   logic              count_zero;
   logic [HOUR_W-1:0] dec_hours;
   logic [5:0]        dec_minutes;
   logic [5:0]        dec_seconds;
   logic              dec_zero;
   logic [5:0]        sat_minutes;
   logic [5:0]        sat_seconds;

   // One-second decrement with borrow, zero detection and load saturation
   always_comb begin
      tick        = (presc_q == PRESC_MAX);
      count_zero  = (hours_q == '0) && (minutes_q == 6'd0) && (seconds_q == 6'd0);
      dec_hours   = hours_q;
      dec_minutes = minutes_q;
      dec_seconds = seconds_q;
      if (seconds_q != 6'd0) begin
         dec_seconds = seconds_q - 6'd1;
      end else if (minutes_q != 6'd0) begin
         dec_minutes = minutes_q - 6'd1;
         dec_seconds = 6'd59;
      end else if (hours_q != '0) begin
         dec_hours   = hours_q - HOUR_W'(1);
         dec_minutes = 6'd59;
         dec_seconds = 6'd59;
      end
      dec_zero    = (dec_hours == '0) && (dec_minutes == 6'd0) && (dec_seconds == 6'd0);
      sat_minutes = (load_minutes > 6'd59) ? 6'd59 : load_minutes;
      sat_seconds = (load_seconds > 6'd59) ? 6'd59 : load_seconds;
   end

   // Next-state logic: clear > load > start > pause, otherwise count in RUN/ALARM
   always_comb begin
      state_d    = state_q;
      hours_d    = hours_q;
      minutes_d  = minutes_q;
      seconds_d  = seconds_q;
      presc_d    = presc_q;
      buzz_cnt_d = buzz_cnt_q;
      buzzer_d   = buzzer_q;
      expired_d  = 1'b0;

      if (clear) begin
         state_d    = S_IDLE;
         hours_d    = '0;
         minutes_d  = 6'd0;
         seconds_d  = 6'd0;
         presc_d    = '0;
         buzz_cnt_d = '0;
         buzzer_d   = 1'b0;
      end else if (load && (state_q != S_RUN)) begin
         state_d    = S_IDLE;
         hours_d    = load_hours;
         minutes_d  = sat_minutes;
         seconds_d  = sat_seconds;
         presc_d    = '0;
         buzz_cnt_d = '0;
         buzzer_d   = 1'b0;
      end else if (start && ((state_q == S_IDLE) || (state_q == S_PAUSED)) && !count_zero) begin
         state_d = S_RUN;
         presc_d = '0;
      end else if (pause && (state_q == S_RUN)) begin
         state_d = S_PAUSED;
      end else if ((state_q == S_RUN) || (state_q == S_ALARM)) begin
         presc_d = tick ? '0 : presc_q + PW'(1);
         if (tick) begin
            if (state_q == S_RUN) begin
               hours_d   = dec_hours;
               minutes_d = dec_minutes;
               seconds_d = dec_seconds;
               if (dec_zero) begin
                  state_d    = S_ALARM;
                  buzzer_d   = 1'b1;
                  expired_d  = 1'b1;
                  buzz_cnt_d = '0;
               end
            end else if (buzz_cnt_q == BUZZ_LAST) begin
               state_d    = S_IDLE;
               buzzer_d   = 1'b0;
               buzz_cnt_d = '0;
            end else begin
               buzz_cnt_d = buzz_cnt_q + BW'(1);
            end
         end
      end

      running_d = (state_d == S_RUN);
   end

   // State and registered outputs, synchronous active-high reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         hours_q    <= '0;
         minutes_q  <= 6'd0;
         seconds_q  <= 6'd0;
         presc_q    <= '0;
         buzz_cnt_q <= '0;
         running_q  <= 1'b0;
         expired_q  <= 1'b0;
         buzzer_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         hours_q    <= hours_d;
         minutes_q  <= minutes_d;
         seconds_q  <= seconds_d;
         presc_q    <= presc_d;
         buzz_cnt_q <= buzz_cnt_d;
         running_q  <= running_d;
         expired_q  <= expired_d;
         buzzer_q   <= buzzer_d;
      end
   end

   assign cur_hours   = hours_q;
   assign cur_minutes = minutes_q;
   assign cur_seconds = seconds_q;
   assign running     = running_q;
   assign expired     = expired_q;
   assign buzzer      = buzzer_q;

endmodule

// File: tb/tb_countdown_timer_core.sv
// tb/tb_countdown_timer_core.sv - self-checking bench for countdown_timer_core
module tb_countdown_timer_core;

   localparam int CLK_DIV = 4;
   localparam int HOUR_W  = 4;
   localparam int BUZZ    = 3;

   logic              clk = 1'b0;
   logic              rst, clear, load, start, pause;
   logic [HOUR_W-1:0] load_hours;
   logic [5:0]        load_minutes, load_seconds;
   logic [HOUR_W-1:0] cur_hours;
   logic [5:0]        cur_minutes, cur_seconds;
   logic              running, expired, buzzer;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   countdown_timer_core #(
      .CLK_DIV(CLK_DIV),
      .HOUR_W(HOUR_W),
      .BUZZ_SECONDS(BUZZ)
   ) dut (
      .clk(clk),
      .rst(rst),
      .clear(clear),
      .load(load),
      .start(start),
      .pause(pause),
      .load_hours(load_hours),
      .load_minutes(load_minutes),
      .load_seconds(load_seconds),
      .cur_hours(cur_hours),
      .cur_minutes(cur_minutes),
      .cur_seconds(cur_seconds),
      .running(running),
      .expired(expired),
      .buzzer(buzzer)
   );

   // reference model: remaining time as a plain number of seconds
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_ALARM = 3;
   int m_mode = M_IDLE;
   int m_total = 0;
   int m_phase = 0;
   int m_alarm_left = 0;
   bit m_exp = 0;
   bit m_buzz = 0;

   function automatic int min59(input int v);
      return (v > 59) ? 59 : v;
   endfunction

   task automatic model_step();
      if (rst) begin
         m_mode = M_IDLE; m_total = 0; m_phase = 0; m_alarm_left = 0; m_exp = 0; m_buzz = 0;
         return;
      end
      m_exp = 0;
      if (clear) begin
         m_mode = M_IDLE; m_total = 0; m_phase = 0; m_buzz = 0;
      end else if (load && m_mode != M_RUN) begin
         m_total = int'(load_hours) * 3600 + min59(int'(load_minutes)) * 60 + min59(int'(load_seconds));
         m_mode = M_IDLE; m_buzz = 0;
      end else if (start && (m_mode == M_IDLE || m_mode == M_PAUSED) && m_total != 0) begin
         m_mode = M_RUN; m_phase = 0;
      end else if (pause && m_mode == M_RUN) begin
         m_mode = M_PAUSED;
      end else if (m_mode == M_RUN || m_mode == M_ALARM) begin
         m_phase++;
         if (m_phase == CLK_DIV) begin
            m_phase = 0;
            if (m_mode == M_RUN) begin
               m_total--;
               if (m_total == 0) begin
                  m_mode = M_ALARM; m_buzz = 1; m_exp = 1; m_alarm_left = BUZZ;
               end
            end else begin
               m_alarm_left--;
               if (m_alarm_left == 0) begin
                  m_mode = M_IDLE; m_buzz = 0;
               end
            end
         end
      end
   endtask

   task automatic check(input string name, input int eh, input int em, input int es,
                        input bit er, input bit eb, input bit ee);
      vectors++;
      if (int'(cur_hours) != eh || int'(cur_minutes) != em || int'(cur_seconds) != es ||
          running !== er || buzzer !== eb || expired !== ee) begin
         miscompares++;
         $display("FAIL %s t=%0t: got %0d:%0d:%0d run=%0b buz=%0b exp=%0b, want %0d:%0d:%0d run=%0b buz=%0b exp=%0b",
                  name, $time, cur_hours, cur_minutes, cur_seconds, running, buzzer, expired,
                  eh, em, es, er, eb, ee);
      end
   endtask

   task automatic drive(input bit r, input bit c, input bit l, input bit st, input bit p,
                        input int h, input int m, input int s);
      rst = r; clear = c; load = l; start = st; pause = p;
      load_hours = HOUR_W'(h); load_minutes = 6'(m); load_seconds = 6'(s);
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // one clock: advance model on the edge, compare 1 time unit later
   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      check("model", m_total / 3600, (m_total / 60) % 60, m_total % 60,
            m_mode == M_RUN, m_buzz, m_exp);
   endtask

   typedef struct {
      bit rst, clr, ld, st, ps;
      int lh, lm, ls, cyc;
      int eh, em, es;
      bit er, eb, ee;
   } vec_t;

   vec_t tbl[18];

   initial begin
      drive(1, 0, 0, 0, 0, 0, 0, 0);

      tbl[0]  = '{1,0,0,0,0, 0, 0, 0,1, 0, 0, 0, 0,0,0};
      tbl[1]  = '{0,0,1,0,0, 1, 0, 0,1, 1, 0, 0, 0,0,0};
      tbl[2]  = '{0,0,0,1,0, 0, 0, 0,1, 1, 0, 0, 1,0,0};
      tbl[3]  = '{0,0,0,0,0, 0, 0, 0,4, 0,59,59, 1,0,0};
      tbl[4]  = '{0,1,0,0,0, 0, 0, 0,1, 0, 0, 0, 0,0,0};
      tbl[5]  = '{0,0,1,0,0, 0,63,60,1, 0,59,59, 0,0,0};
      tbl[6]  = '{0,1,0,0,0, 0, 0, 0,1, 0, 0, 0, 0,0,0};
      tbl[7]  = '{0,0,0,1,0, 0, 0, 0,1, 0, 0, 0, 0,0,0};
      tbl[8]  = '{0,0,1,1,1, 0, 1, 0,1, 0, 1, 0, 0,0,0};
      tbl[9]  = '{0,0,0,0,0, 0, 0, 0,3, 0, 1, 0, 0,0,0};
      tbl[10] = '{0,0,0,1,0, 0, 0, 0,1, 0, 1, 0, 1,0,0};
      tbl[11] = '{0,0,0,0,0, 0, 0, 0,4, 0, 0,59, 1,0,0};
      tbl[12] = '{0,1,0,1,0, 0, 0, 0,1, 0, 0, 0, 0,0,0};
      tbl[13] = '{0,0,1,0,1, 2, 3, 4,1, 2, 3, 4, 0,0,0};
      tbl[14] = '{0,0,0,1,0, 0, 0, 0,1, 2, 3, 4, 1,0,0};
      tbl[15] = '{0,0,1,0,0, 5, 5, 5,1, 2, 3, 4, 1,0,0};
      tbl[16] = '{0,0,0,0,0, 0, 0, 0,3, 2, 3, 3, 1,0,0};
      tbl[17] = '{1,0,0,0,0, 0, 0, 0,1, 0, 0, 0, 0,0,0};

      for (int i = 0; i < 18; i++) begin
         drive(tbl[i].rst, tbl[i].clr, tbl[i].ld, tbl[i].st, tbl[i].ps,
               tbl[i].lh, tbl[i].lm, tbl[i].ls);
         for (int c = 0; c < tbl[i].cyc; c++) step();
         check($sformatf("tbl%0d", i), tbl[i].eh, tbl[i].em, tbl[i].es,
               tbl[i].er, tbl[i].eb, tbl[i].ee);
      end

      // expiry and buzzer timing from 0:00:03
      drive(0, 0, 1, 0, 0, 0, 0, 3); step();
      drive(0, 0, 0, 1, 0, 0, 0, 0); step();
      check("t1_start", 0, 0, 3, 1, 0, 0);
      idle();
      for (int j = 1; j <= 26; j++) begin
         step();
         check($sformatf("t1_k+%0d", j), 0, 0, (j < 4) ? 3 : (j < 8) ? 2 : (j < 12) ? 1 : 0,
               j < 12, (j >= 12) && (j < 24), j == 12);
      end

      // pause holds the count, resume restarts a full second
      drive(0, 0, 1, 0, 0, 0, 0, 10); step();
      drive(0, 0, 0, 1, 0, 0, 0, 0); step();
      idle();
      for (int j = 0; j < 8; j++) step();
      check("t3_run8", 0, 0, 8, 1, 0, 0);
      drive(0, 0, 0, 0, 1, 0, 0, 0); step();
      idle();
      for (int j = 0; j < 20; j++) begin
         step();
         check("t3_hold", 0, 0, 8, 0, 0, 0);
      end
      drive(0, 0, 0, 1, 0, 0, 0, 0); step();
      idle();
      for (int j = 1; j <= 4; j++) begin
         step();
         check($sformatf("t3_resume%0d", j), 0, 0, (j < 4) ? 8 : 7, 1, 0, 0);
      end
      drive(0, 1, 0, 0, 0, 0, 0, 0); step();

      // reset during ALARM leaves no residual buzzer
      drive(0, 0, 1, 0, 0, 0, 0, 1); step();
      drive(0, 0, 0, 1, 0, 0, 0, 0); step();
      idle();
      for (int j = 0; j < 4; j++) step();
      check("t6_expire", 0, 0, 0, 0, 1, 1);
      step();
      check("t6_alarm", 0, 0, 0, 0, 1, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0); step();
      check("t6_rst", 0, 0, 0, 0, 0, 0);
      idle();
      for (int j = 0; j < 12; j++) begin
         step();
         check("t6_quiet", 0, 0, 0, 0, 0, 0);
      end

      // randomized control traffic against the model
      for (int j = 0; j < 1500; j++) begin
         drive(($urandom % 150) == 0, ($urandom % 60) == 0, ($urandom % 10) == 0,
               ($urandom % 4) == 0, ($urandom % 12) == 0,
               (($urandom % 4) == 0) ? int'($urandom % 16) : 0,
               (($urandom % 4) == 0) ? int'($urandom % 64) : int'($urandom % 2),
               (($urandom % 4) == 0) ? int'($urandom % 64) : int'($urandom % 6));
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
